// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: store-and-forward AXI-stream packet FIFO.
// Whole packets are buffered and only become visible to the read side once
// their tlast beat has been written. A packet that runs into a full buffer is
// discarded as a unit, so downstream never sees a truncated frame.
//
// Write FSM states
//   state   | meaning
//   IDLE    | between packets, next accepted beat starts a new packet
//   PKT     | inside a packet, beats are being written to the RAM
//   DROP    | packet overflowed, beats are swallowed until its tlast
module axis_pkt_fifo #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_axis_rx_tvalid_i,
    input  logic [DATA_W-1:0] s_axis_rx_tdata_i,
    input  logic [KEEP_W-1:0] s_axis_rx_tkeep_i,
    input  logic              s_axis_rx_tlast_i,
    output logic              s_axis_rx_tready_o,
    output logic              m_axis_tx_tvalid_o,
    output logic [DATA_W-1:0] m_axis_tx_tdata_o,
    output logic [KEEP_W-1:0] m_axis_tx_tkeep_o,
    output logic              m_axis_tx_tlast_o,
    input  logic              m_axis_tx_tready_i,
    output logic [ADDR_W:0]   occupancy_o,
    output logic [CNT_W-1:0]  pkt_count_o,
    output logic [CNT_W-1:0]  drop_count_o
);

    localparam int WORD_W = DATA_W + KEEP_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_OCC = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_DROP
    } wr_state_t;

    // Packet buffer, word layout {tlast, tkeep, tdata}; contents are never reset
    logic [WORD_W-1:0] mem [0:DEPTH-1];
    logic [WORD_W-1:0] rdata_q;

    wr_state_t state_q, state_d;

    // wr_ptr: next write slot; pkt_start_ptr: first beat of the open packet;
    // commit_ptr: end of the last complete packet; rd_ptr: beats handed
    // downstream (frees space); fetch_ptr: next RAM read address
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] pkt_start_ptr_q, pkt_start_ptr_d;
    logic [ADDR_W:0] commit_ptr_q, commit_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] fetch_ptr_q, fetch_ptr_d;

    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    // Read pipeline: one RAM read in flight plus a 2-entry skid buffer
    logic              rvalid_q, rvalid_d;
    logic [WORD_W-1:0] skid_q [0:1];
    logic              skid_head_q, skid_head_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;

    logic [ADDR_W:0]   occ;
    logic              full;
    logic              in_ready;
    logic              in_hs;
    logic              wr_en;
    logic              out_valid;
    logic [WORD_W-1:0] out_word;
    logic              pop;
    logic              skid_push;
    logic              skid_pop;
    logic              skid_tail;
    logic [2:0]        slots_used;
    logic              rd_issue;

    // Occupancy counts everything not yet handed downstream, including beats
    // already sitting in the skid buffer, so a stalled output fills to DEPTH.
    assign occ  = wr_ptr_q - rd_ptr_q;
    assign full = (occ == FULL_OCC);

    assign in_ready = !reset && ((state_q == ST_DROP) || !full);
    assign in_hs    = s_axis_rx_tvalid_i && in_ready;
    assign wr_en    = in_hs && (state_q != ST_DROP);

    // The skid head takes priority; with the skid empty the RAM read register
    // is presented directly, which is what gives the 2-cycle commit latency.
    assign out_valid = !reset && ((skid_cnt_q != 2'd0) || rvalid_q);
    assign out_word  = (skid_cnt_q != 2'd0) ? skid_q[skid_head_q] : rdata_q;
    assign pop       = out_valid && m_axis_tx_tready_i;

    // A returning read parks in the skid unless it leaves straight away.
    assign skid_push = rvalid_q && !((skid_cnt_q == 2'd0) && pop);
    assign skid_pop  = pop && (skid_cnt_q != 2'd0);
    assign skid_tail = skid_head_q ^ skid_cnt_q[0];

    // Skid entries plus the in-flight read never exceed two.
    assign slots_used = {1'b0, skid_cnt_q} + {2'b00, rvalid_q} - {2'b00, pop};
    assign rd_issue   = !reset && (fetch_ptr_q != commit_ptr_q) && (slots_used < 3'd2);

    // Write FSM next state, pointer updates and counters
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        pkt_start_ptr_d = pkt_start_ptr_q;
        commit_ptr_d    = commit_ptr_q;
        pkt_count_d     = pkt_count_q;
        drop_count_d    = drop_count_q;
        case (state_q)
            ST_IDLE, ST_PKT: begin
                if (s_axis_rx_tvalid_i && full) begin
                    // rewind over the partial packet; its beats are abandoned
                    state_d  = ST_DROP;
                    wr_ptr_d = pkt_start_ptr_q;
                end else if (in_hs) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (s_axis_rx_tlast_i) begin
                        state_d         = ST_IDLE;
                        commit_ptr_d    = wr_ptr_q + 1'b1;
                        pkt_start_ptr_d = wr_ptr_q + 1'b1;
                        pkt_count_d     = pkt_count_q + 1'b1;
                    end else begin
                        state_d = ST_PKT;
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_rx_tvalid_i && s_axis_rx_tlast_i) begin
                    state_d = ST_IDLE;
                    if (drop_count_q != {CNT_W{1'b1}}) begin
                        drop_count_d = drop_count_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-side pointer, in-flight flag and skid bookkeeping
    always_comb begin
        rd_ptr_d    = rd_ptr_q + (ADDR_W+1)'(pop);
        fetch_ptr_d = fetch_ptr_q + (ADDR_W+1)'(rd_issue);
        rvalid_d    = rd_issue;
        skid_head_d = skid_head_q ^ skid_pop;
        skid_cnt_d  = skid_cnt_q + 2'(skid_push) - 2'(skid_pop);
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            pkt_start_ptr_q <= '0;
            commit_ptr_q    <= '0;
            rd_ptr_q        <= '0;
            fetch_ptr_q     <= '0;
            pkt_count_q     <= '0;
            drop_count_q    <= '0;
            rvalid_q        <= 1'b0;
            skid_head_q     <= 1'b0;
            skid_cnt_q      <= 2'd0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            pkt_start_ptr_q <= pkt_start_ptr_d;
            commit_ptr_q    <= commit_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fetch_ptr_q     <= fetch_ptr_d;
            pkt_count_q     <= pkt_count_d;
            drop_count_q    <= drop_count_d;
            rvalid_q        <= rvalid_d;
            skid_head_q     <= skid_head_d;
            skid_cnt_q      <= skid_cnt_d;
        end
    end

    // RAM write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_rx_tlast_i, s_axis_rx_tkeep_i, s_axis_rx_tdata_i};
        end
    end

    // RAM read port, one cycle latency
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            rdata_q <= mem[fetch_ptr_q[ADDR_W-1:0]];
        end
    end

    // Skid storage; only valid entries are ever presented, so no reset needed
    always_ff @(posedge clk) begin
        if (skid_push) begin
            skid_q[skid_tail] <= rdata_q;
        end
    end

    // Output data is forced to zero whenever nothing is being offered
    assign s_axis_rx_tready_o = in_ready;
    assign m_axis_tx_tvalid_o = out_valid;
    assign m_axis_tx_tdata_o  = out_valid ? out_word[DATA_W-1:0] : '0;
    assign m_axis_tx_tkeep_o  = out_valid ? out_word[DATA_W +: KEEP_W] : '0;
    assign m_axis_tx_tlast_o  = out_valid && out_word[WORD_W-1];
    assign occupancy_o        = occ;
    assign pkt_count_o        = pkt_count_q;
    assign drop_count_o       = drop_count_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: directed sequences plus a random-traffic run,
// with a queue-based scoreboard checked by an independent output monitor.
module tb_axis_pkt_fifo;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 512;
    localparam int WORD_W = DATA_W + KEEP_W + 1;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [79:0]       cmp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_tvalid;
    logic [DATA_W-1:0] s_tdata;
    logic [KEEP_W-1:0] s_tkeep;
    logic              s_tlast;
    logic              s_tready;
    logic              m_tvalid;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tlast;
    logic              m_tready;
    logic [ADDR_W:0]   occupancy;
    logic [CNT_W-1:0]  pkt_count;
    logic [CNT_W-1:0]  drop_count;

    axis_pkt_fifo #(
        .DATA_W(DATA_W),
        .KEEP_W(KEEP_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .s_axis_rx_tvalid_i(s_tvalid),
        .s_axis_rx_tdata_i (s_tdata),
        .s_axis_rx_tkeep_i (s_tkeep),
        .s_axis_rx_tlast_i (s_tlast),
        .s_axis_rx_tready_o(s_tready),
        .m_axis_tx_tvalid_o(m_tvalid),
        .m_axis_tx_tdata_o (m_tdata),
        .m_axis_tx_tkeep_o (m_tkeep),
        .m_axis_tx_tlast_o (m_tlast),
        .m_axis_tx_tready_i(m_tready),
        .occupancy_o       (occupancy),
        .pkt_count_o       (pkt_count),
        .drop_count_o      (drop_count)
    );

    always #5 clk = ~clk;

    word_t m_word;
    assign m_word = {m_tlast, m_tkeep, m_tdata};

    word_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    first_hs_cyc = 0;
    int    last_hs_cyc = 0;
    bit    arm_first = 1'b0;
    int    rdy_mode = 1;
    int    acc_cyc = 0;
    int    in_acc = 0;
    bit    stall_pending = 1'b0;
    word_t held;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input cmp_t act, input cmp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: 0 = held low, 1 = held high, 2 = random per cycle
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: every handshake is checked against the scoreboard head,
    // and a stalled beat must stay valid and unchanged until taken.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_pending = 1'b0;
            end else begin
                if (stall_pending) chk("hold_stable", {m_tvalid, m_word}, {1'b1, held});
                if (m_tvalid && m_tready) begin
                    hs_count++;
                    last_hs_cyc = cyc;
                    if (arm_first) begin
                        first_hs_cyc = cyc;
                        arm_first = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got %0h expected no beat", m_word);
                    end else begin
                        chk("beat", m_word, exp_q.pop_front());
                    end
                    stall_pending = 1'b0;
                end else if (m_tvalid) begin
                    stall_pending = 1'b1;
                    held = m_word;
                end else begin
                    stall_pending = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // keep_mode: 0 = all 0xFF, 1 = 0xFF with last beat 0x0F, 2 = random
    task automatic send_pkt(input int len, input bit expect_out, input bit partial,
                            input int keep_mode, input bit gaps);
        for (int i = 0; i < len; i++) begin
            logic [DATA_W-1:0] d;
            logic [KEEP_W-1:0] k;
            bit last;
            bit acc;
            int waitc;
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_tvalid = 1'b0;
                tick();
            end
            d = {$urandom, $urandom};
            if (keep_mode == 2)                      k = 8'($urandom);
            else if (keep_mode == 1 && i == len - 1) k = 8'h0F;
            else                                     k = 8'hFF;
            last = (i == len - 1) && !partial;
            s_tvalid = 1'b1;
            s_tdata  = d;
            s_tkeep  = k;
            s_tlast  = last;
            waitc = 0;
            forever begin
                @(negedge clk);
                acc = s_tready;
                if (acc && last) acc_cyc = cyc;
                tick();
                if (acc) break;
                waitc++;
                if (waitc > 1000) begin
                    bad++;
                    $display("FAIL in_stall: got tready low for %0d cycles expected accept", waitc);
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $fatal(1, "input stalled");
                end
            end
            in_acc++;
            if (expect_out) exp_q.push_back({last, k, d});
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_word", m_word, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_s_tready", s_tready, 1);
        chk("post_rst_occ", occupancy, 0);
        chk("post_rst_pkt", pkt_count, 0);
        chk("post_rst_drop", drop_count, 0);
        tick();
    endtask

    initial begin
        int n;
        int len;
        int hs_base;
        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        repeat (2) tick();
        do_reset();

        // single 8-beat packet, latency from input tlast to first output beat
        rdy_mode = 1;
        send_pkt(8, 1'b1, 1'b0, 1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_tvalid && n < 10);
        chk("latency", cyc - acc_cyc, 2);
        tick();
        wait_drain();
        chk("t1_pkt", pkt_count, 1);

        // ten back-to-back 64-beat packets, output must be gap-free
        do_reset();
        arm_first = 1'b1;
        for (int p = 0; p < 10; p++) send_pkt(64, 1'b1, 1'b0, 0, 1'b0);
        wait_drain();
        chk("no_gaps", last_hs_cyc - first_hs_cyc, 639);
        chk("t2_pkt", pkt_count, 10);
        chk("t2_drop", drop_count, 0);

        // fill to exactly full, then a packet that cannot fit
        do_reset();
        rdy_mode = 0;
        for (int p = 0; p < 8; p++) send_pkt(64, 1'b1, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("t3_occ_full", occupancy, DEPTH);
        chk("t3_tready_full", s_tready, 0);
        tick();
        send_pkt(4, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("t3_drop", drop_count, 1);
        chk("t3_occ_after", occupancy, DEPTH);
        chk("t3_pkt", pkt_count, 8);
        tick();
        rdy_mode = 1;
        wait_drain();
        chk("t3_occ_empty", occupancy, 0);

        // overflow mid-packet rewinds to the previous occupancy
        do_reset();
        rdy_mode = 0;
        for (int p = 0; p < 5; p++) send_pkt(100, 1'b1, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("t4_occ500", occupancy, 500);
        tick();
        send_pkt(20, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        chk("t4_drop", drop_count, 1);
        chk("t4_occ_restored", occupancy, 500);
        tick();
        rdy_mode = 1;
        wait_drain();
        send_pkt(4, 1'b1, 1'b0, 2, 1'b0);
        wait_drain();
        chk("t4_pkt", pkt_count, 6);
        chk("t4_occ_empty", occupancy, 0);

        // random lengths, keeps, input gaps and output backpressure
        do_reset();
        rdy_mode = 2;
        in_acc = 0;
        hs_base = hs_count;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 100);
            n = 0;
            while ((in_acc - (hs_count - hs_base) + len > DEPTH) && n < 20000) begin
                @(negedge clk);
                n++;
            end
            tick();
            send_pkt(len, 1'b1, 1'b0, 2, 1'b1);
        end
        rdy_mode = 1;
        wait_drain();
        chk("t5_pkt", pkt_count, 100);
        chk("t5_drop", drop_count, 0);
        chk("t5_beats", hs_count - hs_base, in_acc);

        // reset mid-packet with two packets buffered discards everything
        do_reset();
        rdy_mode = 0;
        send_pkt(8, 1'b0, 1'b0, 0, 1'b0);
        send_pkt(8, 1'b0, 1'b0, 0, 1'b0);
        send_pkt(3, 1'b0, 1'b1, 0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_occ", occupancy, 0);
        chk("t6_pkt", pkt_count, 0);
        chk("t6_drop", drop_count, 0);
        chk("t6_tvalid", m_tvalid, 0);
        tick();
        rdy_mode = 1;
        hs_base = hs_count;
        repeat (20) @(negedge clk);
        chk("t6_no_stale_beats", hs_count - hs_base, 0);
        tick();
        send_pkt(4, 1'b1, 1'b0, 1, 1'b0);
        wait_drain();
        chk("t6_pkt_after", pkt_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
